// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: decode/execute/memory status in, stall/flush/redirect out.
// Optional PIPELINE_PERF_COUNTERS_EN adds the three event counters.
interface pipeline_hazard_controller_if #(
  parameter int NUM_STAGES     = 5,
  parameter int PC_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_wr_en;
  logic                      ex_is_load;
  logic                      muldiv_start;
  logic                      muldiv_done;
  logic                      br_mispredict;
  logic [PC_WIDTH-1:0]       br_target;
  logic                      mem_wait;
  logic [NUM_STAGES-1:0]     stall;
  logic [NUM_STAGES-1:0]     flush;
  logic                      irreg_pc_valid;
  logic [PC_WIDTH-1:0]       irreg_pc;
  logic                      muldiv_clear;
  logic                      muldiv_busy;
`ifdef PIPELINE_PERF_COUNTERS_EN
  logic [31:0]               mispredict_count;
  logic [31:0]               stall_cycle_count;
  logic [31:0]               muldiv_abort_count;
`endif

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output ex_rd_addr, ex_wr_en, ex_is_load,
    output muldiv_start, muldiv_done, br_mispredict, br_target, mem_wait,
    input  stall, flush, irreg_pc_valid, irreg_pc, muldiv_clear, muldiv_busy
`ifdef PIPELINE_PERF_COUNTERS_EN
    , input mispredict_count, stall_cycle_count, muldiv_abort_count
`endif
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  ex_rd_addr, ex_wr_en, ex_is_load,
    input  muldiv_start, muldiv_done, br_mispredict, br_target, mem_wait,
    output stall, flush, irreg_pc_valid, irreg_pc, muldiv_clear, muldiv_busy
`ifdef PIPELINE_PERF_COUNTERS_EN
    , output mispredict_count, stall_cycle_count, muldiv_abort_count
`endif
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// N-stage in-order pipeline hazard controller: stall/flush vectors, fetch redirect, mul/div tracking FSM.
// Optional event counters are compiled in with PIPELINE_PERF_COUNTERS_EN.
module pipeline_hazard_controller #(
  parameter int NUM_STAGES     = 5,
  parameter int EX_STAGE       = 2,
  parameter int PC_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MULDIV_TIMEOUT = 40
) (
  input logic                       clk,
  input logic                       rst,
  pipeline_hazard_controller_if.slave hz
);
  localparam int CNT_W = $clog2(MULDIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(MULDIV_TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stall_c, flush_c;
  logic                  irv_c, clear_c;
  logic [PC_WIDTH-1:0]   irpc_c;
  logic                  load_use, md_timeout, md_term;

  // Stage masks relative to execute and writeback.
  logic [NUM_STAGES-1:0] upto_ex_m, before_ex_m, after_ex_m, ex_m, mem_hold_m, wb_m;
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
    assign upto_ex_m[gi]   = (gi <= EX_STAGE);
    assign before_ex_m[gi] = (gi < EX_STAGE);
    assign ex_m[gi]        = (gi == EX_STAGE);
    assign after_ex_m[gi]  = (gi == EX_STAGE + 1);
    assign mem_hold_m[gi]  = (gi < NUM_STAGES - 1);
    assign wb_m[gi]        = (gi == NUM_STAGES - 1);
  end

  assign load_use = hz.ex_is_load && hz.ex_wr_en && (hz.ex_rd_addr != '0) &&
                    ((hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                     (hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr)));
  assign md_timeout = (state_q == BUSY) && !hz.muldiv_done && (cnt_q == CNT_TMO);
  assign md_term    = ((state_q == IDLE) && hz.muldiv_start) ||
                      ((state_q == BUSY) && !hz.muldiv_done && !md_timeout);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = '0;
    flush_c = '0;
    irv_c   = 1'b0;
    irpc_c  = '0;
    clear_c = 1'b0;
    if (rst) begin
      flush_c = '1;
      clear_c = 1'b1;
    end else if (hz.mem_wait) begin
      stall_c = mem_hold_m;
      flush_c = wb_m;
    end else if (hz.br_mispredict) begin
      flush_c = upto_ex_m;
      irv_c   = 1'b1;
      irpc_c  = hz.br_target;
      if (state_q == BUSY) begin
        clear_c = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      if (state_q == IDLE) begin
        if (hz.muldiv_start) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(1);
        end
      end else if (hz.muldiv_done) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (md_timeout) begin
        clear_c = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Mul/div occupancy outranks a load-use bubble.
      if (md_term) begin
        stall_c = upto_ex_m;
        flush_c = after_ex_m;
      end else if (load_use) begin
        stall_c = before_ex_m;
        flush_c = ex_m;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.stall          = stall_c;
  assign hz.flush          = flush_c;
  assign hz.irreg_pc_valid = irv_c;
  assign hz.irreg_pc       = irpc_c;
  assign hz.muldiv_clear   = clear_c;
  assign hz.muldiv_busy    = (state_q == BUSY) && !rst;

`ifdef PIPELINE_PERF_COUNTERS_EN
  logic [31:0] mis_cnt_q, stall_cnt_q, abort_cnt_q;
  logic        mis_evt, abort_evt;

  assign mis_evt   = !rst && !hz.mem_wait && hz.br_mispredict;
  assign abort_evt = !rst && !hz.mem_wait && !hz.br_mispredict && md_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_cnt_q   <= '0;
      stall_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (mis_evt && (mis_cnt_q != '1))      mis_cnt_q   <= mis_cnt_q + 32'd1;
      if (stall_c[0] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (abort_evt && (abort_cnt_q != '1))  abort_cnt_q <= abort_cnt_q + 32'd1;
    end
  end

  assign hz.mispredict_count   = mis_cnt_q;
  assign hz.stall_cycle_count  = stall_cnt_q;
  assign hz.muldiv_abort_count = abort_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: 5-stage instance fully checked, 7-stage instance on load-use.
module tb_pipeline_hazard_controller;
  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_used, id_rs2_used, ex_wr_en, ex_is_load;
  logic        muldiv_start, muldiv_done, br_mispredict, mem_wait;
  logic [31:0] br_target;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        irv;
    logic [31:0] pc;
    logic        clr;
    logic        busy;
  } exp_t;
  exp_t sb[$];

  pipeline_hazard_controller_if #(.NUM_STAGES(5), .PC_WIDTH(32), .REG_ADDR_WIDTH(5)) bus5 ();
  pipeline_hazard_controller_if #(.NUM_STAGES(7), .PC_WIDTH(32), .REG_ADDR_WIDTH(5)) bus7 ();

  pipeline_hazard_controller #(.NUM_STAGES(5), .EX_STAGE(2), .PC_WIDTH(32),
                               .REG_ADDR_WIDTH(5), .MULDIV_TIMEOUT(40))
    dut5 (.clk(clk), .rst(rst), .hz(bus5.slave));
  pipeline_hazard_controller #(.NUM_STAGES(7), .EX_STAGE(3), .PC_WIDTH(32),
                               .REG_ADDR_WIDTH(5), .MULDIV_TIMEOUT(40))
    dut7 (.clk(clk), .rst(rst), .hz(bus7.slave));

  assign bus5.id_rs1_addr = id_rs1_addr;   assign bus7.id_rs1_addr = id_rs1_addr;
  assign bus5.id_rs2_addr = id_rs2_addr;   assign bus7.id_rs2_addr = id_rs2_addr;
  assign bus5.id_rs1_used = id_rs1_used;   assign bus7.id_rs1_used = id_rs1_used;
  assign bus5.id_rs2_used = id_rs2_used;   assign bus7.id_rs2_used = id_rs2_used;
  assign bus5.ex_rd_addr  = ex_rd_addr;    assign bus7.ex_rd_addr  = ex_rd_addr;
  assign bus5.ex_wr_en    = ex_wr_en;      assign bus7.ex_wr_en    = ex_wr_en;
  assign bus5.ex_is_load  = ex_is_load;    assign bus7.ex_is_load  = ex_is_load;
  assign bus5.muldiv_start = muldiv_start; assign bus7.muldiv_start = muldiv_start;
  assign bus5.muldiv_done = muldiv_done;   assign bus7.muldiv_done = muldiv_done;
  assign bus5.br_mispredict = br_mispredict; assign bus7.br_mispredict = br_mispredict;
  assign bus5.br_target   = br_target;     assign bus7.br_target   = br_target;
  assign bus5.mem_wait    = mem_wait;      assign bus7.mem_wait    = mem_wait;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd_addr = '0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
    muldiv_start = 1'b0; muldiv_done = 1'b0; br_mispredict = 1'b0;
    br_target = '0; mem_wait = 1'b0;
  endtask

  // Push the expectation for this cycle, then compare at the falling edge.
  task automatic cyc(input string tag, input logic [4:0] st, input logic [4:0] fl,
                     input logic iv, input logic [31:0] pc, input logic clr, input logic bsy);
    exp_t e;
    e = '{tag, st, fl, iv, pc, clr, bsy};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_eq({e.tag, ".stall"}, 32'(bus5.stall), 32'(e.stall));
    check_eq({e.tag, ".flush"}, 32'(bus5.flush), 32'(e.flush));
    check_eq({e.tag, ".irv"},   32'(bus5.irreg_pc_valid), 32'(e.irv));
    check_eq({e.tag, ".pc"},    bus5.irreg_pc, e.pc);
    check_eq({e.tag, ".clr"},   32'(bus5.muldiv_clear), 32'(e.clr));
    check_eq({e.tag, ".busy"},  32'(bus5.muldiv_busy), 32'(e.busy));
    $display("%0t %-10s stall=%b flush=%b irv=%0d pc=%h clr=%0d busy=%0d", $time, e.tag,
             bus5.stall, bus5.flush, bus5.irreg_pc_valid, bus5.irreg_pc,
             bus5.muldiv_clear, bus5.muldiv_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_in();
    tick(); cyc("rst0", 5'h00, 5'h1F, 0, 32'h0, 1, 0);
    tick(); cyc("rst1", 5'h00, 5'h1F, 0, 32'h0, 1, 0);
    tick(); rst = 1'b0; cyc("idle", 5'h00, 5'h00, 0, 32'h0, 0, 0);

    // Reset while BUSY with cnt=7
    tick(); muldiv_start = 1'b1; cyc("md_go", 5'h07, 5'h08, 0, 32'h0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      tick(); muldiv_start = 1'b0; cyc("md_run", 5'h07, 5'h08, 0, 32'h0, 0, 1);
    end
    tick(); rst = 1'b1; cyc("rst_busy", 5'h00, 5'h1F, 0, 32'h0, 1, 0);
    tick(); cyc("rst_busy", 5'h00, 5'h1F, 0, 32'h0, 1, 0);
    tick(); rst = 1'b0; cyc("post_rst", 5'h00, 5'h00, 0, 32'h0, 0, 0);

    // Load-use variants
    tick(); ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd_addr = 5'd5;
    id_rs2_addr = 5'd5; id_rs2_used = 1'b1;
    cyc("lu_rs2", 5'h03, 5'h04, 0, 32'h0, 0, 0);
    check_eq("lu7.stall", 32'(bus7.stall), 32'h07);
    check_eq("lu7.flush", 32'(bus7.flush), 32'h08);
    tick(); ex_rd_addr = 5'd0; id_rs2_addr = 5'd0;
    cyc("lu_r0", 5'h00, 5'h00, 0, 32'h0, 0, 0);
    check_eq("lu7_r0.stall", 32'(bus7.stall), 32'h00);
    tick(); clear_in(); ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd_addr = 5'd9;
    id_rs1_addr = 5'd9; id_rs1_used = 1'b1;
    cyc("lu_rs1", 5'h03, 5'h04, 0, 32'h0, 0, 0);
    tick(); id_rs1_used = 1'b0; cyc("lu_unused", 5'h00, 5'h00, 0, 32'h0, 0, 0);
    tick(); id_rs1_used = 1'b1; ex_wr_en = 1'b0; cyc("lu_nowr", 5'h00, 5'h00, 0, 32'h0, 0, 0);
    tick(); ex_wr_en = 1'b1; ex_is_load = 1'b0; cyc("lu_noload", 5'h00, 5'h00, 0, 32'h0, 0, 0);

    // Mul/div with done at T+4; load-use at T+2 is outranked
    tick(); clear_in(); muldiv_start = 1'b1; cyc("md_T", 5'h07, 5'h08, 0, 32'h0, 0, 0);
    tick(); muldiv_start = 1'b0; cyc("md_T1", 5'h07, 5'h08, 0, 32'h0, 0, 1);
    tick(); ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd_addr = 5'd3;
    id_rs1_addr = 5'd3; id_rs1_used = 1'b1;
    cyc("md_T2_lu", 5'h07, 5'h08, 0, 32'h0, 0, 1);
    tick(); clear_in(); cyc("md_T3", 5'h07, 5'h08, 0, 32'h0, 0, 1);
    tick(); muldiv_done = 1'b1; cyc("md_done", 5'h00, 5'h00, 0, 32'h0, 0, 1);
    tick(); muldiv_done = 1'b0; cyc("md_after", 5'h00, 5'h00, 0, 32'h0, 0, 0);

    // Timeout: no done, start held high (ignored while BUSY)
    tick(); muldiv_start = 1'b1; cyc("to_go", 5'h07, 5'h08, 0, 32'h0, 0, 0);
    for (int i = 1; i <= 39; i++) begin
      tick(); cyc("to_run", 5'h07, 5'h08, 0, 32'h0, 0, 1);
    end
    tick(); muldiv_start = 1'b0; cyc("to_abort", 5'h00, 5'h00, 0, 32'h0, 1, 1);
    tick(); cyc("to_idle", 5'h00, 5'h00, 0, 32'h0, 0, 0);

    // Priority: mem_wait over mispredict, then mispredict alone
    tick(); br_mispredict = 1'b1; br_target = 32'h0000_0100; mem_wait = 1'b1;
    cyc("pr_mw", 5'h0F, 5'h10, 0, 32'h0, 0, 0);
    tick(); mem_wait = 1'b0; cyc("pr_br", 5'h00, 5'h07, 1, 32'h100, 0, 0);
    tick(); clear_in(); cyc("pr_idle", 5'h00, 5'h00, 0, 32'h0, 0, 0);

    // mem_wait freezes BUSY; mispredict then aborts the op
    tick(); muldiv_start = 1'b1; cyc("fz_go", 5'h07, 5'h08, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); muldiv_start = 1'b0; mem_wait = 1'b1; muldiv_done = 1'b1;
      cyc("fz_mw", 5'h0F, 5'h10, 0, 32'h0, 0, 1);
    end
    tick(); clear_in(); br_mispredict = 1'b1; br_target = 32'h0000_0200;
    cyc("fz_br", 5'h00, 5'h07, 1, 32'h200, 1, 1);
    tick(); clear_in(); cyc("fz_idle", 5'h00, 5'h00, 0, 32'h0, 0, 0);
    tick(); br_mispredict = 1'b1; br_target = 32'hDEAD_BEE0;
    cyc("br3", 5'h00, 5'h07, 1, 32'hDEAD_BEE0, 0, 0);
    tick(); clear_in(); cyc("br3_after", 5'h00, 5'h00, 0, 32'h0, 0, 0);
`ifdef PIPELINE_PERF_COUNTERS_EN
    check_eq("mispredict_count", bus5.mispredict_count, 32'd3);
    check_eq("muldiv_abort_count", bus5.muldiv_abort_count, 32'd1);
    check_eq("mispredict_count7", bus7.mispredict_count, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Parametrised successor to the fixed five-stage controller. It generates per-stage stall and flush vectors for an N-stage in-order pipeline from load-use hazards, memory wait, branch mispredicts and a multi-cycle mul/div unit. It also drives the fetch redirect (irregular PC) and the mul/div clear. It sits beside the pipeline and is driven by decode, execute and memory-access status, with a small FSM tracking the mul/div operation.

Parameters:
NUM_STAGES, 5, pipeline stage count; stage 0 = fetch, stage NUM_STAGES-1 = writeback; legal range 4..8
EX_STAGE, 2, index of the execute stage; 1 <= EX_STAGE <= NUM_STAGES-3
PC_WIDTH, 32, PC width
REG_ADDR_WIDTH, 5, register index width
MULDIV_TIMEOUT, 40, maximum BUSY cycles before forced abort; must be >= 2

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
id_rs1_addr  input  REG_ADDR_WIDTH  decode-stage source 1
id_rs2_addr  input  REG_ADDR_WIDTH  decode-stage source 2
id_rs1_used  input  1  source 1 is read
id_rs2_used  input  1  source 2 is read
ex_rd_addr  input  REG_ADDR_WIDTH  execute-stage destination
ex_wr_en  input  1  execute-stage instruction writes rd
ex_is_load  input  1  execute-stage instruction is a load
muldiv_start  input  1  mul/div op issued in EX this cycle
muldiv_done  input  1  mul/div result valid this cycle
br_mispredict  input  1  EX resolved a mispredicted branch
br_target  input  PC_WIDTH  correct target
mem_wait  input  1  memory-access stage not ready
stall  output  NUM_STAGES  per-stage hold (bit i = stage i)
flush  output  NUM_STAGES  per-stage bubble insert
irreg_pc_valid  output  1  fetch redirect request
irreg_pc  output  PC_WIDTH  redirect target
muldiv_clear  output  1  abort mul/div unit
muldiv_busy  output  1  FSM in BUSY

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Outputs are combinational from FSM state and the current inputs. Only the FSM and its counter are registered.
- While rst=1: stall=0, flush=all ones, irreg_pc_valid=0, irreg_pc=0, muldiv_clear=1, muldiv_busy=0.
- On the first clk edge with rst=1: FSM goes to IDLE and cnt=0. This also applies with an op in flight; muldiv_busy is 0 from the following cycle.
- Conditions are evaluated in this priority order; the first that matches wins.
- 1. mem_wait=1:
  - stall[NUM_STAGES-2:0]=all ones, stall[NUM_STAGES-1]=0.
  - flush[NUM_STAGES-1]=1; all other flush bits 0.
  - br_mispredict, load-use and muldiv_start are ignored; upstream holds them stable.
  - FSM and cnt freeze. muldiv_done is ignored this cycle.
- 2. br_mispredict=1:
  - flush[EX_STAGE:0]=all ones, stall=0.
  - irreg_pc_valid=1, irreg_pc=br_target, same cycle.
  - If FSM=BUSY: muldiv_clear=1 and FSM goes to IDLE next edge.
- 3. Mul/div stall term = (IDLE & muldiv_start) | (BUSY & ~muldiv_done). When the term is 1:
  - stall[EX_STAGE:0]=all ones.
  - flush[EX_STAGE+1]=1.
- 4. Load-use:
  - Condition: ex_is_load & ex_wr_en & ex_rd_addr!=0 & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
  - Response: stall[EX_STAGE-1:0]=all ones, flush[EX_STAGE]=1, for one cycle per matching cycle.
  - Register 0 never hazards.
- Otherwise stall=0, flush=0, irreg_pc_valid=0.
- When irreg_pc_valid=0, irreg_pc=0.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY on muldiv_start (outside mem_wait/mispredict); cnt <= 1.
  - BUSY & muldiv_done -> IDLE; no stall in the done cycle.
  - BUSY & ~done: cnt <= cnt+1.
  - BUSY & cnt==MULDIV_TIMEOUT & ~done: muldiv_clear=1 that cycle, stall term forced to 0, -> IDLE.
- cnt width = $clog2(MULDIV_TIMEOUT+1) and never wraps.
- muldiv_busy = (state==BUSY).
- muldiv_start while BUSY is ignored.

Optional Feature:
- Macro: PIPELINE_PERF_COUNTERS_EN.
- When defined, adds outputs mispredict_count[31:0], stall_cycle_count[31:0] and muldiv_abort_count[31:0]. All reset to 0 and saturate at 2^32-1.
  - mispredict_count increments on each cycle with a priority-2 match.
  - stall_cycle_count increments on any cycle with stall[0]=1.
  - muldiv_abort_count increments on each timeout.
- When undefined, the ports and registers are absent and the rest of the block's behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles mid-BUSY (cnt=7) -> flush=5'b11111, muldiv_clear=1; after release muldiv_busy=0, stall=0.
- Load-use: ex_is_load=1, ex_wr_en=1, ex_rd_addr=5, id_rs2_addr=5, id_rs2_used=1 -> stall=5'b00011, flush=5'b00100; same case with ex_rd_addr=0 -> stall=0.
- Mul/div: muldiv_start at cycle T, muldiv_done at T+4 -> stall=5'b00111 and flush=5'b01000 in T..T+3; stall=0 at T+4; muldiv_busy high T+1..T+4.
- Timeout: MULDIV_TIMEOUT=40, start without done -> muldiv_clear=1 on the cycle cnt==40, FSM IDLE next cycle, stall released that cycle.
- Priority: br_mispredict=1, br_target=32'h0000_0100 with mem_wait=1 -> stall=5'b01111, flush=5'b10000, irreg_pc_valid=0. Drop mem_wait -> irreg_pc_valid=1, irreg_pc=32'h100, flush=5'b00111.
- Generalisation: NUM_STAGES=7, EX_STAGE=3 with load-use -> stall=7'b0000111, flush=7'b0001000. With PIPELINE_PERF_COUNTERS_EN, 3 mispredicts -> mispredict_count=3.
